// File: rtl/stop_it_ng.sv
// ---------------------------------------------------------------------------
// stop_it_ng -- "stop it" reaction game.
//
// The player presses go, a short STARTING phase shows both displays, then a
// counter runs (down or up) until the player presses stop.  Stopping on the
// target value advances the LED level bar; stopping with a full bar wins.
// The target is taken from a free-running Fibonacci LFSR when the game starts.
//
// Optional feature (macro STOP_IT_LIVES_EN): a three-life counter; running
// out of lives on a wrong stop clears the LED level bar.
//
// Parameters
//   COUNT_W      width of counter, target and LFSR (3..8)
//   LEVELS       number of LED level positions (2..32)
//   START_TICKS  cycles spent in STARTING (>= 2)
//   RESULT_TICKS cycles spent in WRONG / CORRECT (even, >= 2)
//   MODE         0 = count down from all-ones, 1 = count up from zero
//   TAPS         LFSR feedback tap mask
//
// Ports
//   clk_4_i      clock, rising edge
//   rst_i        synchronous active-high reset
//   go_i         start a game / leave WON
//   stop_i       stop the counter
//   load_i       preload LEDs from switches_i while idle
//   switches_i   LED preload value
//   leds_o       level indicator
//   count_o      game counter
//   target_o     target value
//   count_en_o   counter display enable
//   target_en_o  target display enable
//   state_o      IDLE=0 STARTING=1 COUNTING=2 WRONG=3 CORRECT=4 WON=5
// ---------------------------------------------------------------------------
module stop_it_ng #(
   parameter int                 COUNT_W      = 5,
   parameter int                 LEVELS       = 16,
   parameter int                 START_TICKS  = 8,
   parameter int                 RESULT_TICKS = 16,
   parameter int                 MODE         = 0,
   parameter logic [COUNT_W-1:0] TAPS         = COUNT_W'(5'b10100)
) (
   input  logic               clk_4_i,
   input  logic               rst_i,
   input  logic               go_i,
   input  logic               stop_i,
   input  logic               load_i,
   input  logic [LEVELS-1:0]  switches_i,
   output logic [LEVELS-1:0]  leds_o,
   output logic [COUNT_W-1:0] count_o,
   output logic [COUNT_W-1:0] target_o,
   output logic               count_en_o,
   output logic               target_en_o,
   output logic [2:0]         state_o
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_STARTING = 3'd1,
      ST_COUNTING = 3'd2,
      ST_WRONG    = 3'd3,
      ST_CORRECT  = 3'd4,
      ST_WON      = 3'd5
   } state_t;

   // The phase timer only has to reach the longer of the two fixed phases;
   // in WON it simply free-runs and wraps.
   localparam int TMAX    = (START_TICKS > RESULT_TICKS) ? START_TICKS : RESULT_TICKS;
   localparam int TIMER_W = $clog2(TMAX);

   localparam logic [TIMER_W-1:0] START_LAST  = TIMER_W'(START_TICKS - 1);
   localparam logic [TIMER_W-1:0] RESULT_LAST = TIMER_W'(RESULT_TICKS - 1);

   localparam logic [COUNT_W-1:0] COUNT_INIT = (MODE == 0) ? {COUNT_W{1'b1}} : '0;

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [COUNT_W-1:0]   lfsr_q, lfsr_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic [COUNT_W-1:0]   target_q, target_d;
   logic [LEVELS-1:0]    leds_q, leds_d;
   logic                 win_q, win_d;

   logic                 start_done;
   logic                 result_done;
   logic                 on_target;
   logic                 leds_full;
   logic                 lfsr_fb;
   logic                 lfsr_run;
   logic                 lives_out;

   assign start_done  = (timer_q == START_LAST);
   assign result_done = (timer_q == RESULT_LAST);
   assign on_target   = (count_q == target_q);
   assign leds_full   = (leds_q == {LEVELS{1'b1}});
   assign lfsr_fb     = ^(lfsr_q & TAPS);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (go_i) state_d = ST_STARTING;
         end
         ST_STARTING: begin
            if (start_done) state_d = ST_COUNTING;
         end
         ST_COUNTING: begin
            if (stop_i) state_d = on_target ? ST_CORRECT : ST_WRONG;
         end
         ST_WRONG: begin
            if (result_done) state_d = ST_IDLE;
         end
         ST_CORRECT: begin
            if (result_done) state_d = win_q ? ST_WON : ST_IDLE;
         end
         ST_WON: begin
            if (go_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef STOP_IT_LIVES_EN
   localparam logic [1:0] LIVES = 2'd3;

   logic [1:0] lives_q, lives_d;

   // A life is lost on entering WRONG; the last cycle of a WRONG phase with
   // no lives left wipes the level bar and hands out a fresh set of lives.
   assign lives_out = (state_q == ST_WRONG) && result_done && (lives_q == 2'd0);

   always_comb begin
      lives_d = lives_q;
      if ((state_q == ST_COUNTING) && (state_d == ST_WRONG)) begin
         lives_d = lives_q - 2'd1;
      end else if (lives_out) begin
         lives_d = LIVES;
      end
   end

   always_ff @(posedge clk_4_i) begin
      if (rst_i) begin
         lives_q <= LIVES;
      end else begin
         lives_q <= lives_d;
      end
   end
`else
   assign lives_out = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Datapath next values
   // ------------------------------------------------------------------------
   assign lfsr_run = (state_q == ST_IDLE) || (state_q == ST_WRONG) ||
                     (state_q == ST_CORRECT);

   always_comb begin
      // Timer restarts at zero whenever the state changes.
      timer_d = (state_d != state_q) ? '0 : timer_q + TIMER_W'(1);

      // All-zeros is the LFSR lock-up state; kick it back to 1.
      lfsr_d = lfsr_q;
      if (lfsr_q == '0) begin
         lfsr_d = COUNT_W'(1);
      end else if (lfsr_run) begin
         lfsr_d = {lfsr_q[COUNT_W-2:0], lfsr_fb};
      end

      target_d = target_q;
      if ((state_q == ST_IDLE) && go_i) begin
         target_d = lfsr_q;
      end

      count_d = count_q;
      if ((state_q == ST_STARTING) && start_done) begin
         count_d = COUNT_INIT;
      end else if ((state_q == ST_COUNTING) && !stop_i) begin
         count_d = (MODE == 0) ? count_q - COUNT_W'(1) : count_q + COUNT_W'(1);
      end

      win_d = win_q;
      if ((state_q == ST_COUNTING) && stop_i && on_target && leds_full) begin
         win_d = 1'b1;
      end else if ((state_q == ST_WON) && go_i) begin
         win_d = 1'b0;
      end

      leds_d = leds_q;
      case (state_q)
         ST_IDLE: begin
            // go_i wins over load_i in the same cycle
            if (!go_i && load_i) leds_d = switches_i;
         end
         ST_CORRECT: begin
            if (result_done && !win_q) leds_d = {leds_q[LEVELS-2:0], 1'b1};
         end
         ST_WRONG: begin
            if (lives_out) leds_d = '0;
         end
         ST_WON: begin
            if (go_i) leds_d = '0;
         end
         default: leds_d = leds_q;
      endcase
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_4_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         lfsr_q   <= COUNT_W'(1);
         count_q  <= '0;
         target_q <= '0;
         leds_q   <= '0;
         win_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         lfsr_q   <= lfsr_d;
         count_q  <= count_d;
         target_q <= target_d;
         leds_q   <= leds_d;
         win_q    <= win_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      count_en_o  = 1'b1;
      target_en_o = 1'b0;
      leds_o      = leds_q;
      case (state_q)
         ST_IDLE: begin
            count_en_o  = 1'b1;
            target_en_o = 1'b0;
         end
         ST_STARTING, ST_COUNTING: begin
            count_en_o  = 1'b1;
            target_en_o = 1'b1;
         end
         ST_WRONG: begin
            // displays alternate
            count_en_o  = ~timer_q[0];
            target_en_o = timer_q[0];
         end
         ST_CORRECT: begin
            // displays flash together
            count_en_o  = ~timer_q[0];
            target_en_o = ~timer_q[0];
         end
         ST_WON: begin
            count_en_o  = 1'b1;
            target_en_o = 1'b1;
            leds_o      = timer_q[0] ? '0 : {LEVELS{1'b1}};
         end
         default: begin
            count_en_o  = 1'b1;
            target_en_o = 1'b0;
         end
      endcase
   end

   assign count_o  = count_q;
   assign target_o = target_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_stop_it_ng.sv
// ---------------------------------------------------------------------------
// tb_stop_it_ng -- self-checking bench for stop_it_ng.
// u_dut: default parameters.  u_up: MODE=1, COUNT_W=3 for the wrap check.
// ---------------------------------------------------------------------------
module tb_stop_it_ng;

   localparam int M_ST  = 1;
   localparam int M_LED = 2;
   localparam int M_CNT = 4;
   localparam int M_EN  = 8;
   localparam int M_TGT = 16;
   localparam int ALL   = 31;

   logic        clk = 1'b0;
   logic        rst = 1'b0, go = 1'b0, stop = 1'b0, load = 1'b0;
   logic [15:0] switches = '0;
   logic [15:0] leds;
   logic [4:0]  cnt, tgt;
   logic        cen, ten;
   logic [2:0]  st;

   logic        rst1 = 1'b0, go1 = 1'b0, stop1 = 1'b0, load1 = 1'b0;
   logic [3:0]  switches1 = '0;
   logic [3:0]  leds1;
   logic [2:0]  cnt1, tgt1;
   logic        cen1, ten1;
   logic [2:0]  st1;

   stop_it_ng u_dut (
      .clk_4_i(clk), .rst_i(rst), .go_i(go), .stop_i(stop), .load_i(load),
      .switches_i(switches), .leds_o(leds), .count_o(cnt), .target_o(tgt),
      .count_en_o(cen), .target_en_o(ten), .state_o(st)
   );

   stop_it_ng #(
      .COUNT_W(3), .LEVELS(4), .START_TICKS(2), .RESULT_TICKS(2), .MODE(1),
      .TAPS(3'b110)
   ) u_up (
      .clk_4_i(clk), .rst_i(rst1), .go_i(go1), .stop_i(stop1), .load_i(load1),
      .switches_i(switches1), .leds_o(leds1), .count_o(cnt1), .target_o(tgt1),
      .count_en_o(cen1), .target_en_o(ten1), .state_o(st1)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    dut;
      string nm;
      int    st;
      int    leds;
      int    cnt;
      int    tgt;
      int    cen;
      int    ten;
      int    mask;
   } exp_t;

   typedef struct {
      int rst, go, stop, load, sw;
      int st, leds, cnt, cen, ten, mask;
   } vec_t;

   exp_t       sb_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         m_state = 0;
   logic [4:0] m_lfsr  = 5'd1;
   int         m_tgt   = 0;

   function automatic logic [4:0] lfsr_step(input logic [4:0] v);
      if (v == 5'd0) return 5'd1;
      return {v[3:0], ^(v & 5'b10100)};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic sb_check();
      exp_t e;
      int a_st, a_l, a_c, a_t, a_ce, a_te;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard: got empty queue, expected an entry");
         return;
      end
      e = sb_q.pop_front();
      if (e.dut == 0) begin
         a_st = int'(st); a_l = int'(leds); a_c = int'(cnt); a_t = int'(tgt);
         a_ce = int'(cen); a_te = int'(ten);
      end else begin
         a_st = int'(st1); a_l = int'(leds1); a_c = int'(cnt1); a_t = int'(tgt1);
         a_ce = int'(cen1); a_te = int'(ten1);
      end
      if ((e.mask & M_ST)  != 0) chk({e.nm, ".state"},     a_st, e.st);
      if ((e.mask & M_LED) != 0) chk({e.nm, ".leds"},      a_l,  e.leds);
      if ((e.mask & M_CNT) != 0) chk({e.nm, ".count"},     a_c,  e.cnt);
      if ((e.mask & M_TGT) != 0) chk({e.nm, ".target"},    a_t,  e.tgt);
      if ((e.mask & M_EN)  != 0) begin
         chk({e.nm, ".count_en"},  a_ce, e.cen);
         chk({e.nm, ".target_en"}, a_te, e.ten);
      end
   endtask

   // Drive one cycle of stimulus on u_dut, queue the expectation for the
   // state after the next rising edge, then compare.
   task automatic cyc(input int r, input int g, input int s, input int l, input int sw,
                      input int e_st, input int e_leds, input int e_cnt,
                      input int e_cen, input int e_ten, input int mask, input string nm);
      exp_t e;
      rst = r[0]; go = g[0]; stop = s[0]; load = l[0]; switches = sw[15:0];
      if (r != 0) begin
         m_lfsr = 5'd1;
         m_tgt  = 0;
      end else begin
         if (m_state == 0 && g != 0) m_tgt = int'(m_lfsr);
         if (m_state == 0 || m_state == 3 || m_state == 4) m_lfsr = lfsr_step(m_lfsr);
      end
      m_state = e_st;
      e.dut = 0; e.nm = nm; e.st = e_st; e.leds = e_leds; e.cnt = e_cnt;
      e.tgt = m_tgt; e.cen = e_cen; e.ten = e_ten; e.mask = mask;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      sb_check();
   endtask

   task automatic cyc1(input int r, input int g, input int s,
                       input int e_st, input int e_cnt, input string nm);
      exp_t e;
      rst1 = r[0]; go1 = g[0]; stop1 = s[0];
      e.dut = 1; e.nm = nm; e.st = e_st; e.leds = 0; e.cnt = e_cnt;
      e.tgt = 0; e.cen = 0; e.ten = 0; e.mask = M_ST | M_CNT;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      sb_check();
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, ALL, "reset");
   endtask

   task automatic idle(input int lv, input int ld, input int sw, input string nm);
      cyc(0, 0, 0, ld, sw, 0, lv, 0, 1, 0, M_ST | M_LED | M_EN, nm);
   endtask

   task automatic idle_until_31(input int lv);
      int n;
      n = 0;
      while (m_lfsr != 5'd31 && n < 40) begin
         idle(lv, 0, 0, "idle_wait");
         n++;
      end
   endtask

   // From IDLE: go, whole STARTING phase (stop/load poked and ignored),
   // first COUNTING cycle with the count preset.
   task automatic start_game(input int lv);
      cyc(0, 1, 0, 0, 0, 1, lv, 0, 1, 1, M_ST | M_LED | M_EN | M_TGT, "go");
      for (int i = 1; i < 8; i++) begin
         cyc(0, 0, (i == 3) ? 1 : 0, (i == 4) ? 1 : 0, 16'hFFFF,
             1, lv, 0, 1, 1, M_ST | M_LED | M_EN | M_TGT, "starting");
      end
      cyc(0, 0, 0, 0, 0, 2, lv, 31, 1, 1, ALL, "count_start");
   endtask

   task automatic wrong_phase(input int c, input int lv, input int lv_after);
      cyc(0, 0, 1, 0, 0, 3, lv, c, 1, 0, ALL, "stop_wrong");
      for (int i = 1; i < 16; i++) begin
         cyc(0, 0, 0, 0, 0, 3, lv, c, 1 - (i % 2), i % 2, ALL, "wrong");
      end
      cyc(0, 0, 0, 0, 0, 0, lv_after, c, 1, 0, ALL, "wrong_end");
   endtask

   task automatic correct_phase(input int lv, input int won, input int lv_after);
      cyc(0, 0, 1, 0, 0, 4, lv, 31, 1, 1, ALL, "stop_correct");
      for (int i = 1; i < 16; i++) begin
         cyc(0, 0, 0, 0, 0, 4, lv, 31, 1 - (i % 2), 1 - (i % 2), ALL, "correct");
      end
      if (won != 0) cyc(0, 0, 0, 0, 0, 5, 16'hFFFF, 31, 1, 1, M_ST | M_LED | M_CNT | M_TGT, "won_enter");
      else          cyc(0, 0, 0, 0, 0, 0, lv_after, 31, 1, 0, ALL, "correct_end");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[13];
      @(posedge clk);
      #1;

      // Up-counter instance: 0..7 then wrap to 0
      cyc1(1, 0, 0, 0, 0, "up_reset");
      cyc1(0, 1, 0, 1, 0, "up_go");
      cyc1(0, 0, 0, 1, 0, "up_starting");
      cyc1(0, 0, 0, 2, 0, "up_count0");
      for (int i = 1; i <= 8; i++) cyc1(0, 0, 0, 2, i % 8, $sformatf("up_count%0d", i));
      cyc1(1, 0, 0, 0, 0, "up_reset2");

      // Reset, preload, go priority over load, STARTING length, count preset
      tbl[0]  = '{1, 0, 0, 0, 0,       0, 0,       0,  1, 0, ALL};
      tbl[1]  = '{0, 0, 0, 1, 'h00F0,  0, 'h00F0,  0,  1, 0, ALL};
      tbl[2]  = '{0, 1, 0, 1, 'hFFFF,  1, 'h00F0,  0,  1, 1, ALL};
      for (int i = 3; i <= 9; i++) tbl[i] = '{0, 0, (i == 5) ? 1 : 0, 0, 0, 1, 'h00F0, 0, 1, 1, ALL};
      tbl[10] = '{0, 0, 0, 0, 0,       2, 'h00F0, 31,  1, 1, ALL};
      tbl[11] = '{0, 0, 0, 1, 'hFFFF,  2, 'h00F0, 30,  1, 1, ALL};
      tbl[12] = '{0, 0, 0, 0, 0,       2, 'h00F0, 29,  1, 1, ALL};
      for (int k = 0; k < 13; k++) begin
         cyc(tbl[k].rst, tbl[k].go, tbl[k].stop, tbl[k].load, tbl[k].sw,
             tbl[k].st, tbl[k].leds, tbl[k].cnt, tbl[k].cen, tbl[k].ten,
             tbl[k].mask, $sformatf("vec%0d", k));
      end

      // Correct stop on first COUNTING cycle: 00F8 -> 01F1
      do_reset();
      idle(16'h00F8, 1, 16'h00F8, "load_f8");
      idle_until_31(16'h00F8);
      start_game(16'h00F8);
      correct_phase(16'h00F8, 0, 16'h01F1);

      // Stop one cycle late: WRONG, LEDs untouched
      do_reset();
      idle(16'h00F8, 1, 16'h00F8, "load_f8b");
      idle_until_31(16'h00F8);
      start_game(16'h00F8);
      cyc(0, 0, 0, 0, 0, 2, 16'h00F8, 30, 1, 1, ALL, "count30");
      wrong_phase(30, 16'h00F8, 16'h00F8);

      // Full bar and correct stop: WON flashing, go clears
      do_reset();
      idle(16'hFFFF, 1, 16'hFFFF, "load_ffff");
      idle_until_31(16'hFFFF);
      start_game(16'hFFFF);
      correct_phase(16'hFFFF, 1, 0);
      for (int i = 1; i <= 6; i++) begin
         cyc(0, 0, 0, 0, 0, 5, (i % 2 == 1) ? 0 : 16'hFFFF, 31, 1, 1,
             M_ST | M_LED | M_CNT, "won_flash");
      end
      cyc(0, 1, 0, 0, 0, 0, 0, 31, 1, 0, ALL, "won_go");

`ifdef STOP_IT_LIVES_EN
      // Three wrong stops use up the lives and clear the bar
      do_reset();
      idle(16'h00F0, 1, 16'h00F0, "load_lives");
      for (int r = 0; r < 3; r++) begin
         int c;
         start_game(16'h00F0);
         c = 31;
         if (m_tgt == 31) begin
            cyc(0, 0, 0, 0, 0, 2, 16'h00F0, 30, 1, 1, ALL, "count_dn");
            c = 30;
         end
         wrong_phase(c, 16'h00F0, (r == 2) ? 0 : 16'h00F0);
      end
`endif

      // Reset in the middle of COUNTING overrides every other input
      do_reset();
      idle(16'h00F0, 1, 16'h00F0, "load_mid");
      start_game(16'h00F0);
      cyc(0, 0, 0, 0, 0, 2, 16'h00F0, 30, 1, 1, ALL, "count30b");
      cyc(1, 1, 1, 1, 16'hFFFF, 0, 0, 0, 1, 0, ALL, "rst_mid");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stop_it_ng.md
STOP_IT_NG -- requirements
Module: stop_it_ng

Interface
REQ-001 Parameter COUNT_W, default 5: width of the game counter, target and LFSR, range 3..8.
REQ-002 Parameter LEVELS, default 16: number of LED level positions, range 2..32.
REQ-003 Parameter START_TICKS, default 8: length of the STARTING state in clock cycles, minimum 2.
REQ-004 Parameter RESULT_TICKS, default 16: length of the WRONG and CORRECT states in cycles, even, minimum 2.
REQ-005 Parameter MODE, default 0: 0 selects count-down, 1 selects count-up.
REQ-006 Parameter TAPS, default 5'b10100: LFSR feedback tap mask, COUNT_W bits wide.
REQ-007 Port clk_4_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-009 Ports go_i, stop_i and load_i, inputs, 1 bit each: level-sampled, already synchronised commands.
REQ-010 Port switches_i, input, LEVELS bits: LED preload value.
REQ-011 Port leds_o, output, LEVELS bits: level indicator.
REQ-012 Port count_o, output, COUNT_W bits: game counter value.
REQ-013 Port target_o, output, COUNT_W bits: target value.
REQ-014 Ports count_en_o and target_en_o, outputs, 1 bit each: display enables.
REQ-015 Port state_o, output, 3 bits: state encoding, IDLE=0, STARTING=1, COUNTING=2, WRONG=3, CORRECT=4, WON=5.

Function
REQ-016 The state machine SHALL have the states IDLE, STARTING, COUNTING, WRONG, CORRECT and WON; any other encoding SHALL go to IDLE on the next cycle.
REQ-017 The LFSR SHALL be a Fibonacci LFSR using TAPS, SHALL advance every cycle in IDLE, WRONG and CORRECT, and SHALL hold in all other states.
REQ-018 The LFSR SHALL never hold all-zeros; if it does, it SHALL load 1 on the next cycle.
REQ-019 In IDLE: count_en_o=1 and target_en_o=0; load_i=1 SHALL set leds_o<=switches_i; go_i=1 SHALL move the machine to STARTING, with go_i taking priority over load_i in the same cycle.
REQ-020 target_o SHALL latch the LFSR value on the IDLE->STARTING transition and SHALL hold it until the next IDLE->STARTING transition.
REQ-021 STARTING SHALL last exactly START_TICKS cycles, with both enables at 1; stop_i and load_i SHALL be ignored.
REQ-022 On the STARTING->COUNTING transition, count_o SHALL load 2^COUNT_W-1 when MODE=0, or 0 when MODE=1.
REQ-023 In COUNTING, count_o SHALL change by one (-1 for MODE=0, +1 for MODE=1) on every cycle in which stop_i=0, and SHALL wrap modulo 2^COUNT_W.
REQ-024 When stop_i=1 in COUNTING, count_o SHALL freeze and the current value SHALL be compared with target_o: equal goes to CORRECT, unequal goes to WRONG, on the next cycle.
REQ-025 A correct stop SHALL set the win flag when leds_o is all-ones at the stop cycle.
REQ-026 WRONG SHALL last RESULT_TICKS cycles: count_en_o equals NOT timer[0] and target_en_o equals timer[0] (alternating); then the machine SHALL return to IDLE.
REQ-027 CORRECT SHALL last RESULT_TICKS cycles: both enables equal NOT timer[0] (flashing together).
REQ-028 On the last CORRECT cycle: with the win flag set, the machine SHALL go to WON; otherwise leds_o<={leds_o[LEVELS-2:0],1'b1} and the machine SHALL go to IDLE.
REQ-029 In WON: leds_o SHALL read all-ones when timer[0]=0 and all-zeros when timer[0]=1; the free-running timer SHALL wrap; go_i=1 SHALL clear the LEDs and the win flag and return the machine to IDLE.
REQ-030 The phase timer SHALL clear on every state change.

Reset
REQ-031 When rst_i=1 at a clock edge, the next-cycle values SHALL be: state IDLE; leds_o, count_o, target_o and timer 0; LFSR 1; win flag 0; lives LIVES; count_en_o=1; target_en_o=0.
REQ-032 rst_i SHALL take precedence over all inputs in every state, including mid-COUNTING and WON.

Configuration
REQ-033 With STOP_IT_LIVES_EN defined, a lives counter SHALL reset to LIVES=3 and SHALL decrement on entry to WRONG.
REQ-034 With STOP_IT_LIVES_EN defined, on the last WRONG cycle with lives=0, leds_o SHALL clear and lives SHALL reload to 3.
REQ-035 Without STOP_IT_LIVES_EN, no lives logic SHALL exist and WRONG SHALL never modify leds_o.

Verification
REQ-036 Defaults; reset, load_i with switches_i=16'h00F0, then go_i -> leds_o=00F0 and state_o=1 for exactly 8 cycles, then count_o=31 in COUNTING.
REQ-037 LFSR forced so target=31; stop_i asserted on the first COUNTING cycle -> CORRECT, then after 16 cycles leds_o=0x01F1 and state IDLE.
REQ-038 Target=31 with stop_i one cycle late (count=30) -> WRONG; count_en_o and target_en_o alternate for 16 cycles; leds_o unchanged.
REQ-039 leds_o=FFFF and a correct stop -> WON; leds_o toggles FFFF/0000 each cycle; go_i -> IDLE with leds_o=0.
REQ-040 MODE=1 with COUNT_W=3; no stop for 9 cycles -> count_o sequence 0..7,0 (wrap).
REQ-041 STOP_IT_LIVES_EN defined: three wrong stops -> leds_o cleared at the end of the third WRONG; rst_i asserted mid-COUNTING -> IDLE with all reset values on the next cycle.
